// File: rtl/wb_arbiter.sv
// Writeback arbiter: main-path writes pass straight through; long-latency results queue in a FIFO
// and drain into free register-file slots. Tracks pending destinations and flags drain starvation.
module wb_arbiter #(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pipe_we,
   input  logic [4:0]  pipe_addr,
   input  logic [31:0] pipe_data,
   input  logic        lu_valid,
   output logic        lu_ready,
   input  logic [4:0]  lu_addr,
   input  logic [31:0] lu_data,
   input  logic        issue_valid,
   input  logic [4:0]  issue_addr,
   output logic [31:0] pending,
   output logic        stall_req,
   output logic        rf_we,
   output logic [4:0]  rf_addr,
   output logic [31:0] rf_data
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [7:0]  StarveMax = 8'(STARVE_LIMIT);

   logic [4:0]      addr_q [DEPTH];
   logic [31:0]     data_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic [31:0]     pending_q, pending_d;
   logic [7:0]      starve_q, starve_d;
   logic            stall_q;

   logic pipe_busy, fifo_empty, push, drain;
   logic [4:0] head_addr;

   assign pipe_busy  = pipe_we && (pipe_addr != 5'd0);
   assign fifo_empty = (count_q == '0);
   assign lu_ready   = (count_q < CntW'(DEPTH));
   // x0 results complete the handshake but are dropped here
   assign push       = lu_valid && lu_ready && (lu_addr != 5'd0);
   assign drain      = !pipe_busy && !fifo_empty;
   assign head_addr  = addr_q[rd_ptr_q];

   assign pending    = pending_q;
   assign stall_req  = stall_q;

   always_comb begin
      rf_we   = 1'b0;
      rf_addr = 5'd0;
      rf_data = 32'd0;
      if (pipe_busy) begin
         rf_we   = 1'b1;
         rf_addr = pipe_addr;
         rf_data = pipe_data;
      end else if (!fifo_empty) begin
         rf_we   = 1'b1;
         rf_addr = head_addr;
         rf_data = data_q[rd_ptr_q];
      end
   end

   always_comb begin
      count_d = count_q;
      unique case ({push, drain})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Clear for the drained head first so a same-cycle issue to that register wins
   always_comb begin
      pending_d = pending_q;
      if (drain) pending_d[head_addr] = 1'b0;
      if (issue_valid && (issue_addr != 5'd0)) pending_d[issue_addr] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_comb begin
      starve_d = starve_q;
      if (fifo_empty || drain) begin
         starve_d = 8'd0;
      end else if (pipe_busy && (starve_q != StarveMax)) begin
         starve_d = starve_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         pending_q <= 32'd0;
         starve_q  <= 8'd0;
         stall_q   <= 1'b0;
      end else begin
         if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
         if (drain) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q   <= count_d;
         pending_q <= pending_d;
         starve_q  <= starve_d;
         stall_q   <= (starve_d == StarveMax);
      end
   end

   // Storage needs no reset: entries are only read once the pointers say they are valid
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr_q] <= lu_addr;
         data_q[wr_ptr_q] <= lu_data;
      end
   end

endmodule
